sll_pipe: RTL

//   32-bit logical left shifter, pipelined as five registered mux layers: one layer per shift-amount bit.

---
 rtl/sll_pipe_if.sv | 24 ++
 rtl/sll_pipe.sv | 119 +++++++++++
 2 files changed

// File: rtl/sll_pipe_if.sv
// Handshake bundle for the pipelined left shifter.
// The producer and consumer sides are grouped so the shifter sees one bus port.
interface sll_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [SHAMT_W-1:0] amt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   Q;

    modport master (
        output in_valid, A, amt, out_ready,
        input  in_ready, out_valid, Q
    );

    modport slave (
        input  in_valid, A, amt, out_ready,
        output in_ready, out_valid, Q
    );
endinterface

// File: rtl/sll_pipe.sv
// 32-bit logical left shifter built as five registered mux layers, one per
// shift-amount bit, with valid/ready flow control and per-stage bubble collapsing.
module sll_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    sll_pipe_if.slave   bus
);
    localparam int NS = SHAMT_W;

    logic [NS-1:0]    v_r;
    logic [WIDTH-1:0] d_r    [NS];
    logic [WIDTH-1:0] d_in_s [NS];
    logic [NS-1:0]    rdy_s;
    logic [NS-1:0]    sel_s;

    // Remaining shift-amount bits shrink by one bit per stage.
    logic [3:0] amt0_r;
    logic [2:0] amt1_r;
    logic [1:0] amt2_r;
    logic       amt3_r;

    function automatic logic [WIDTH-1:0] shl_layer(
        input logic [WIDTH-1:0] d,
        input logic             sel,
        input int unsigned      k
    );
        logic [WIDTH-1:0] r;
        if (sel) begin
            r = d << (32'd1 << k);
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Ready chain: a stage can load when it is empty or its successor can take its content.
    always_comb begin
        rdy_s = {NS{1'b0}};
        rdy_s[NS-1] = !v_r[NS-1] | bus.out_ready;
        for (int k = NS - 2; k >= 0; k--) begin
            rdy_s[k] = !v_r[k] | rdy_s[k+1];
        end
    end

    // Mux select for each layer: stage k consumes amt bit k.
    always_comb begin
        sel_s = {amt3_r, amt2_r[0], amt1_r[0], amt0_r[0], bus.amt[0]};
    end

    // Next data for each stage: one shift layer applied to the previous stage.
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            d_in_s[k] = {WIDTH{1'b0}};
        end
        d_in_s[0] = shl_layer(bus.A, sel_s[0], 32'd0);
        for (int k = 1; k < NS; k++) begin
            d_in_s[k] = shl_layer(d_r[k-1], sel_s[k], k);
        end
    end

    assign bus.in_ready  = rdy_s[0] & !flush;
    assign bus.out_valid = v_r[NS-1];
    assign bus.Q         = d_r[NS-1];

    // Valid and data registers; flush only kills the valids, data is don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= {NS{1'b0}};
            for (int k = 0; k < NS; k++) begin
                d_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (rdy_s[k]) begin
                    d_r[k] <= d_in_s[k];
                end
            end
            if (flush) begin
                v_r <= {NS{1'b0}};
            end else begin
                if (rdy_s[0]) begin
                    v_r[0] <= bus.in_valid & bus.in_ready;
                end
                for (int k = 1; k < NS; k++) begin
                    if (rdy_s[k]) begin
                        v_r[k] <= v_r[k-1];
                    end
                end
            end
        end
    end

    // Unconsumed shift-amount bits travel alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amt0_r <= 4'd0;
            amt1_r <= 3'd0;
            amt2_r <= 2'd0;
            amt3_r <= 1'b0;
        end else begin
            if (rdy_s[0]) begin
                amt0_r <= bus.amt[4:1];
            end
            if (rdy_s[1]) begin
                amt1_r <= amt0_r[3:1];
            end
            if (rdy_s[2]) begin
                amt2_r <= amt1_r[2:1];
            end
            if (rdy_s[3]) begin
                amt3_r <= amt2_r[1];
            end
        end
    end
endmodule
